nms_window_buffer: RTL
======================

Name: nms_window_buffer

Overview:
Upstream neighbour of the non-maximum-suppression stage in the edge-detection pipeline. Accepts a raster stream of per-pixel gradient magnitude (11 b) and quantised direction (2 b) from the gradient stage. Uses two line buffers to assemble a 3x3 neighbourhood around each interior pixel. Emits each window as the packed 99-bit magnitude and 18-bit direction buses that NMS consumes.

Parameters:
IMG_WIDTH, 512, pixels per line; must be >= 3.
IMG_HEIGHT, 512, lines per frame; must be >= 3.

Ports:
clk  input  1  pipeline clock.
rst  input  1  asynchronous, active-high reset.
mag_in  input  11  gradient magnitude of the incoming pixel.
dir_in  input  2  quantised gradient direction of the incoming pixel.
in_valid  input  1  pixel accepted on every clk edge where high; no backpressure.
in_sof  input  1  start of frame; qualified by in_valid; the accompanying pixel is (row 0, col 0).
gradient_magnitude  output  99  3x3 magnitude window; element k at [11k+10:11k].
gradient_direction  output  18  3x3 direction window; element k at [2k+1:2k].
gradient_mag_valid  output  1  window valid strobe.
gradient_dir_valid  output  1  identical to gradient_mag_valid.

Behaviour:
- Clocking and reset: one clock domain (clk); rst is asynchronous and active-high.
- Window indexing: k = 3*wr + wc.
  - wr = 0 is the oldest line (top); wc = 0 is the oldest column (left).
  - k = 4 is the centre; k = 3 and k = 5 are its horizontal neighbours; k = 0 and k = 8 are the top-left and bottom-right diagonals.
  - The centre occupies magnitude [54:44] and direction [9:8].
- Counters: col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) give the position of the pixel being accepted.
  - On an accepted pixel, col increments; at IMG_WIDTH-1, col wraps to 0 and row increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both counters wrap to 0.
  - If in_sof && in_valid, the current pixel is forced to (0,0) regardless of the counters. The counters then continue from (0,1).
- Line buffers: LB_A holds row-1 and LB_B holds row-2; each is IMG_WIDTH x 13 b ({mag,dir}), single read/write address = col.
  - On an accepted pixel, the column vector is {top = LB_B[col], mid = LB_A[col], bottom = input}.
  - In the same cycle, LB_B[col] <= LB_A[col] and LB_A[col] <= input.
  - Line buffer contents are not reset.
- Window shift register: 3 columns x 3 rows x 13 b.
  - On an accepted pixel: wc0 <= wc1, wc1 <= wc2, wc2 <= new column vector.
  - Registers hold when in_valid is low.
- Valid generation:
  - Both valid outputs are registered.
  - They are high for exactly one cycle, in the cycle after accepting pixel (r,c) with r >= 2 and c >= 2.
  - Window data changes only on accepted pixels, so data and valid are aligned.
  - The emitted window is centred on (r-1, c-1).
- Latency: 1 clk from the accepting edge to valid.
- Border rows and columns are never emitted as centres. Windows straddling a line wrap (c < 2) or the first two lines of a frame (r < 2) are suppressed.
- Throughput: one pixel per clk; arbitrary in_valid gaps are allowed.
- Frame boundary: a new frame (via in_sof or natural wrap) never produces a window that mixes lines from two frames, because row < 2 suppresses valid.
- Reset values: all outputs 0, counters 0, window registers 0.
- Reset mid-frame: valid drops asynchronously. The first pixel after reset deassertion is treated as (0,0), and no stale line-buffer data is ever flagged valid.
- If in_sof arrives mid-frame, the partial frame is abandoned with no further windows from it.

Optional Feature:
Macro NMS_WIN_COORD_EN.
- Defined: adds outputs win_row [$clog2(IMG_HEIGHT)-1:0] and win_col [$clog2(IMG_WIDTH)-1:0].
  - They carry the window-centre coordinates (r-1, c-1), registered alongside valid.
  - Reset value 0; they hold when valid is low.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
All scenarios use IMG_WIDTH=4, IMG_HEIGHT=4, and pixel (r,c) driven with mag = 16r+c, dir = (r+c)%4.
1. Assert rst asynchronously mid-clock -> all outputs read 0 immediately; no valid for 20 idle cycles.
2. Contiguous 16-pixel frame with in_sof on the first pixel -> exactly 4 valid strobes, centres (1,1), (1,2), (2,1), (2,2).
   - First window: centre mag 17, k0 = 0, k3 = 16, k5 = 18, k8 = 34; centre dir = 2.
3. Same frame with in_valid toggling 1,0,0,1,... -> identical 4 windows; each valid is a single cycle, one clk after the accepting pixel.
4. Six pixels, then in_sof with a new frame -> no valid from the abandoned frame; the new frame yields exactly 4 correct windows.
5. Two back-to-back frames without a gap -> 8 windows total; no valid during rows 0-1 of frame 2; frame-2 windows contain no frame-1 data.
6. rst pulsed after pixel (2,1) -> no valid for pixel (2,2) of the abandoned frame; the next frame emits its correct 4 windows.
   - With NMS_WIN_COORD_EN defined, win_row/win_col match the centres in every scenario.

Source files
------------

// File: rtl/nms_window_buffer.sv
// -----------------------------------------------------------------------------
// nms_window_buffer
//
// Purpose:
//    Builds a 3x3 neighbourhood of gradient magnitude and direction around
//    every interior pixel of a raster stream, for the non-maximum-suppression
//    stage. Two line buffers hold the previous two lines. A 3-column shift
//    register holds the window. A registered strobe flags each complete
//    window.
//
// Window layout:
//    Element k = 3*wr + wc.
//    wr = 0 is the oldest (top) line; wc = 0 is the oldest (left) column.
//    Magnitude element k is at [11k+10:11k].
//    Direction element k is at [2k+1:2k].
//
// Ports:
//    clk                 pipeline clock
//    rst                 asynchronous, active-high reset
//    mag_in[10:0]        gradient magnitude of the incoming pixel
//    dir_in[1:0]         quantised gradient direction of the incoming pixel
//    in_valid            pixel accepted on every clk edge where high
//    in_sof              start of frame; the accompanying pixel is (0,0)
//    gradient_magnitude  packed 3x3 magnitude window (99 b)
//    gradient_direction  packed 3x3 direction window (18 b)
//    gradient_mag_valid  one-cycle window valid strobe
//    gradient_dir_valid  identical to gradient_mag_valid
//
// Optional feature (macro NMS_WIN_COORD_EN):
//    Adds win_row / win_col, the window-centre coordinates. They are
//    registered alongside the valid strobe.
// -----------------------------------------------------------------------------
module nms_window_buffer #(
   parameter int IMG_WIDTH  = 512,
   parameter int IMG_HEIGHT = 512
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] mag_in,
   input  logic [1:0]  dir_in,
   input  logic        in_valid,
   input  logic        in_sof,
   output logic [98:0] gradient_magnitude,
   output logic [17:0] gradient_direction,
   output logic        gradient_mag_valid,
   output logic        gradient_dir_valid
`ifdef NMS_WIN_COORD_EN
   ,
   output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
   output logic [$clog2(IMG_WIDTH)-1:0]  win_col
`endif
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [CW-1:0] w_col;
   logic [RW-1:0] w_row;
   logic [CW-1:0] w_colNext;
   logic [RW-1:0] w_rowNext;

   logic [12:0]   r_lbA [IMG_WIDTH];
   logic [12:0]   r_lbB [IMG_WIDTH];
   logic [12:0]   r_win [3][3];

   logic [12:0]   w_pixel;
   logic [12:0]   w_top;
   logic [12:0]   w_mid;
   logic          w_emit;
   logic          r_valid;

`ifdef NMS_WIN_COORD_EN
   logic [RW-1:0] r_winRow;
   logic [CW-1:0] r_winCol;
`endif

   // Position of the pixel being accepted.
   // A start-of-frame pixel is forced to (0,0) whatever the counters hold.
   // The same column drives the line-buffer address.
   // A window is emitted only once two full lines and two columns of the
   // current frame exist. This also keeps stale line-buffer contents out
   // after a reset or a new frame.
   always_comb begin
      w_col   = in_sof ? '0 : r_col;
      w_row   = in_sof ? '0 : r_row;
      w_pixel = {mag_in, dir_in};
      w_top   = r_lbB[w_col];
      w_mid   = r_lbA[w_col];
      w_emit  = in_valid && (w_row >= RW'(2)) && (w_col >= CW'(2));
      if (w_col == COL_LAST) begin
         w_colNext = '0;
         w_rowNext = (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
      end else begin
         w_colNext = w_col + CW'(1);
         w_rowNext = w_row;
      end
   end

   // Raster position counters.
   // They advance only on accepted pixels and wrap at the frame end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (in_valid) begin
         r_col <= w_colNext;
         r_row <= w_rowNext;
      end
   end

   // Line buffers.
   // LB_A holds the previous line and LB_B the line before that. Each
   // accepted pixel pushes the column down by one line. The contents are
   // deliberately not reset; the row qualifier on the strobe hides them.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         r_lbB[w_col] <= w_mid;
         r_lbA[w_col] <= w_pixel;
      end
   end

   // Window shift register.
   // The new column vector enters on the right (wc = 2) and the oldest
   // column drops off the left.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int wr = 0; wr < 3; wr++) begin
            for (int wc = 0; wc < 3; wc++) begin
               r_win[wr][wc] <= '0;
            end
         end
      end else if (in_valid) begin
         for (int wr = 0; wr < 3; wr++) begin
            r_win[wr][0] <= r_win[wr][1];
            r_win[wr][1] <= r_win[wr][2];
         end
         r_win[0][2] <= w_top;
         r_win[1][2] <= w_mid;
         r_win[2][2] <= w_pixel;
      end
   end

   // Valid strobe.
   // It is high for the single cycle after the accepting edge, which is
   // exactly when the window register holds the new window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= w_emit;
      end
   end

`ifdef NMS_WIN_COORD_EN
   // Window-centre coordinates.
   // The centre lags the accepted pixel by one line and one column. The
   // value holds between strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_winRow <= '0;
         r_winCol <= '0;
      end else if (w_emit) begin
         r_winRow <= w_row - RW'(1);
         r_winCol <= w_col - CW'(1);
      end
   end

   assign win_row = r_winRow;
   assign win_col = r_winCol;
`endif

   // Flatten the window into the packed buses NMS expects.
   always_comb begin
      gradient_magnitude = '0;
      gradient_direction = '0;
      for (int wr = 0; wr < 3; wr++) begin
         for (int wc = 0; wc < 3; wc++) begin
            gradient_magnitude[11*(3*wr+wc) +: 11] = r_win[wr][wc][12:2];
            gradient_direction[2*(3*wr+wc) +: 2]   = r_win[wr][wc][1:0];
         end
      end
   end

   assign gradient_mag_valid = r_valid;
   assign gradient_dir_valid = r_valid;

endmodule
